// File: rtl/mtsp_gprs_seq_pkg.sv
// rtl/mtsp_gprs_seq_pkg.sv - shared types, widths and helpers for the GPR access sequencer
package mtsp_gprs_seq_pkg;

    localparam int SIZE_GPRS = 7;
    localparam int ADDR_W    = SIZE_GPRS + 1;
    localparam int MASK_W    = 4;
    localparam int DATA_W    = 128;

    // A set mask bit blocks the write of that dword.
    localparam logic [MASK_W-1:0] MASK4D_ALLMASKED = 4'hF;
    localparam logic [5:0]        NEN_IDLE         = 6'b111111;

    typedef enum logic [2:0] {
        SLOT_SRC0A = 3'd0,
        SLOT_SRC0B = 3'd1,
        SLOT_SRC1A = 3'd2,
        SLOT_SRC1B = 3'd3,
        SLOT_WB0   = 3'd4,
        SLOT_WB1   = 3'd5
    } slot_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        logic  valid;
        slot_e slot;
    } tag_t;

    function automatic logic [5:0] slot_to_nen(input slot_e slot);
        return ~(6'b000001 << slot);
    endfunction

endpackage

// File: rtl/mtsp_gprs_access_sequencer_if.sv
// rtl/mtsp_gprs_access_sequencer_if.sv - request, primitive and operand signals of the sequencer
interface mtsp_gprs_access_sequencer_if;
    import mtsp_gprs_seq_pkg::*;

    logic                REQ_VALID;
    logic                REQ_READY;
    logic [3:0]          REQ_SRC_EN;
    logic [1:0]          REQ_WB_EN;
    logic [ADDR_W-1:0]   REQ_SRC0A_ADDR;
    logic [ADDR_W-1:0]   REQ_SRC0B_ADDR;
    logic [ADDR_W-1:0]   REQ_SRC1A_ADDR;
    logic [ADDR_W-1:0]   REQ_SRC1B_ADDR;
    logic [ADDR_W-1:0]   REQ_WB0_ADDR;
    logic [ADDR_W-1:0]   REQ_WB1_ADDR;
    logic [MASK_W-1:0]   REQ_WB0_WMASK;
    logic [MASK_W-1:0]   REQ_WB1_WMASK;
    logic [DATA_W-1:0]   REQ_WB0_DATA;
    logic [DATA_W-1:0]   REQ_WB1_DATA;

    logic [5:0]          nEN;
    logic [ADDR_W-1:0]   SRC0A_ADDR;
    logic [ADDR_W-1:0]   SRC0B_ADDR;
    logic [ADDR_W-1:0]   SRC1A_ADDR;
    logic [ADDR_W-1:0]   SRC1B_ADDR;
    logic [ADDR_W-1:0]   WB0_ADDR;
    logic [ADDR_W-1:0]   WB1_ADDR;
    logic [MASK_W-1:0]   WB0_WMASK;
    logic [MASK_W-1:0]   WB1_WMASK;
    logic [DATA_W-1:0]   WB0_DATA;
    logic [DATA_W-1:0]   WB1_DATA;
    logic [DATA_W-1:0]   RDATA;

    logic                OPR_VALID;
    logic                OPR_READY;
    logic [DATA_W-1:0]   OPR0A;
    logic [DATA_W-1:0]   OPR0B;
    logic [DATA_W-1:0]   OPR1A;
    logic [DATA_W-1:0]   OPR1B;

    modport master (
        input  REQ_VALID, REQ_SRC_EN, REQ_WB_EN,
               REQ_SRC0A_ADDR, REQ_SRC0B_ADDR, REQ_SRC1A_ADDR, REQ_SRC1B_ADDR,
               REQ_WB0_ADDR, REQ_WB1_ADDR, REQ_WB0_WMASK, REQ_WB1_WMASK,
               REQ_WB0_DATA, REQ_WB1_DATA, RDATA, OPR_READY,
        output REQ_READY, nEN,
               SRC0A_ADDR, SRC0B_ADDR, SRC1A_ADDR, SRC1B_ADDR, WB0_ADDR, WB1_ADDR,
               WB0_WMASK, WB1_WMASK, WB0_DATA, WB1_DATA,
               OPR_VALID, OPR0A, OPR0B, OPR1A, OPR1B
    );

    modport slave (
        output REQ_VALID, REQ_SRC_EN, REQ_WB_EN,
               REQ_SRC0A_ADDR, REQ_SRC0B_ADDR, REQ_SRC1A_ADDR, REQ_SRC1B_ADDR,
               REQ_WB0_ADDR, REQ_WB1_ADDR, REQ_WB0_WMASK, REQ_WB1_WMASK,
               REQ_WB0_DATA, REQ_WB1_DATA, RDATA, OPR_READY,
        input  REQ_READY, nEN,
               SRC0A_ADDR, SRC0B_ADDR, SRC1A_ADDR, SRC1B_ADDR, WB0_ADDR, WB1_ADDR,
               WB0_WMASK, WB1_WMASK, WB0_DATA, WB1_DATA,
               OPR_VALID, OPR0A, OPR0B, OPR1A, OPR1B
    );

endinterface

// File: rtl/mtsp_gprs_seq_tag_pipe.sv
// rtl/mtsp_gprs_seq_tag_pipe.sv - delay line of read tags that steers RDATA into operand registers
module mtsp_gprs_seq_tag_pipe
    import mtsp_gprs_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic nRST,
    input  tag_t tag_i,
    output tag_t head_o,
    output logic busy_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign head_o = stage_q[DEPTH-1];

    // The head tag is consumed at this edge, so only tags that survive it keep the pipe busy.
    always_comb begin
        busy_o = tag_i.valid;
        for (int i = 0; i < DEPTH - 1; i++) begin
            busy_o = busy_o | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/mtsp_gprs_access_sequencer.sv
// rtl/mtsp_gprs_access_sequencer.sv - serialises one operand/write-back request onto the GPR primitive port
module mtsp_gprs_access_sequencer
    import mtsp_gprs_seq_pkg::*;
#(
    parameter int CORE_ID      = 0,
    parameter int PRIMITIVE_ID = 0,
    parameter int RD_LAT       = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    mtsp_gprs_access_sequencer_if.master bus
);

    if (RD_LAT < 1 || RD_LAT > 4 || CORE_ID < 0 || PRIMITIVE_ID < 0) begin : g_param_check
        $error("mtsp_gprs_access_sequencer: illegal parameter value");
    end

    state_e            state_q;
    logic [5:0]        pend_q;
    logic [5:0]        pend_d;
    logic [5:0]        nen_q;
    logic              req_ready_q;
    logic              opr_valid_q;
    logic              iss_rd_q;
    slot_e             iss_slot_q;

    logic [ADDR_W-1:0] src0a_addr_q, src0b_addr_q, src1a_addr_q, src1b_addr_q;
    logic [ADDR_W-1:0] wb0_addr_q, wb1_addr_q;
    logic [MASK_W-1:0] wb0_wmask_q, wb1_wmask_q;
    logic [DATA_W-1:0] wb0_data_q, wb1_data_q;
    logic [DATA_W-1:0] opr0a_q, opr0b_q, opr1a_q, opr1b_q;

    logic              pick_found;
    slot_e             pick_slot;
    tag_t              head;
    logic              pipe_busy;

    // Lowest pending slot wins, which keeps reads ahead of writes.
    always_comb begin
        pick_found = 1'b0;
        pick_slot  = SLOT_SRC0A;
        for (int i = 5; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick_found = 1'b1;
                pick_slot  = slot_e'(3'(i));
            end
        end
        pend_d = pick_found ? (pend_q & slot_to_nen(pick_slot)) : pend_q;
    end

    mtsp_gprs_seq_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .CLK    (CLK),
        .nRST   (nRST),
        .tag_i  ('{valid: iss_rd_q, slot: iss_slot_q}),
        .head_o (head),
        .busy_o (pipe_busy)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            nen_q        <= NEN_IDLE;
            req_ready_q  <= 1'b1;
            opr_valid_q  <= 1'b0;
            iss_rd_q     <= 1'b0;
            iss_slot_q   <= SLOT_SRC0A;
            src0a_addr_q <= '0;
            src0b_addr_q <= '0;
            src1a_addr_q <= '0;
            src1b_addr_q <= '0;
            wb0_addr_q   <= '0;
            wb1_addr_q   <= '0;
            wb0_wmask_q  <= MASK4D_ALLMASKED;
            wb1_wmask_q  <= MASK4D_ALLMASKED;
            wb0_data_q   <= '0;
            wb1_data_q   <= '0;
            opr0a_q      <= '0;
            opr0b_q      <= '0;
            opr1a_q      <= '0;
            opr1b_q      <= '0;
        end else begin
            nen_q    <= NEN_IDLE;
            iss_rd_q <= 1'b0;

            if (head.valid) begin
                case (head.slot)
                    SLOT_SRC0A: opr0a_q <= bus.RDATA;
                    SLOT_SRC0B: opr0b_q <= bus.RDATA;
                    SLOT_SRC1A: opr1a_q <= bus.RDATA;
                    SLOT_SRC1B: opr1b_q <= bus.RDATA;
                    default:    ;
                endcase
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.REQ_VALID) begin
                        src0a_addr_q <= bus.REQ_SRC0A_ADDR;
                        src0b_addr_q <= bus.REQ_SRC0B_ADDR;
                        src1a_addr_q <= bus.REQ_SRC1A_ADDR;
                        src1b_addr_q <= bus.REQ_SRC1B_ADDR;
                        wb0_addr_q   <= bus.REQ_WB0_ADDR;
                        wb1_addr_q   <= bus.REQ_WB1_ADDR;
                        wb0_wmask_q  <= bus.REQ_WB0_WMASK;
                        wb1_wmask_q  <= bus.REQ_WB1_WMASK;
                        wb0_data_q   <= bus.REQ_WB0_DATA;
                        wb1_data_q   <= bus.REQ_WB1_DATA;
                        pend_q       <= {bus.REQ_WB_EN, bus.REQ_SRC_EN};
                        opr0a_q      <= '0;
                        opr0b_q      <= '0;
                        opr1a_q      <= '0;
                        opr1b_q      <= '0;
                        req_ready_q  <= 1'b0;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (pick_found) begin
                        nen_q      <= slot_to_nen(pick_slot);
                        iss_rd_q   <= ~pick_slot[2];
                        iss_slot_q <= pick_slot;
                        pend_q     <= pend_d;
                        if (pend_d == 6'b0) begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_busy) begin
                        opr_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.OPR_READY) begin
                        opr_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.REQ_READY  = req_ready_q;
    assign bus.nEN        = nen_q;
    assign bus.SRC0A_ADDR = src0a_addr_q;
    assign bus.SRC0B_ADDR = src0b_addr_q;
    assign bus.SRC1A_ADDR = src1a_addr_q;
    assign bus.SRC1B_ADDR = src1b_addr_q;
    assign bus.WB0_ADDR   = wb0_addr_q;
    assign bus.WB1_ADDR   = wb1_addr_q;
    assign bus.WB0_WMASK  = wb0_wmask_q;
    assign bus.WB1_WMASK  = wb1_wmask_q;
    assign bus.WB0_DATA   = wb0_data_q;
    assign bus.WB1_DATA   = wb1_data_q;
    assign bus.OPR_VALID  = opr_valid_q;
    assign bus.OPR0A      = opr0a_q;
    assign bus.OPR0B      = opr0b_q;
    assign bus.OPR1A      = opr1a_q;
    assign bus.OPR1B      = opr1b_q;

endmodule

// File: tb/tb_mtsp_gprs_access_sequencer.sv
// tb/tb_mtsp_gprs_access_sequencer.sv - directed self-checking bench for the GPR access sequencer
module tb_mtsp_gprs_access_sequencer;
    import mtsp_gprs_seq_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mtsp_gprs_access_sequencer_if bus ();

    mtsp_gprs_access_sequencer #(
        .CORE_ID      (0),
        .PRIMITIVE_ID (0),
        .RD_LAT       (2)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_hs = 0;
    int onehot_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Primitive model: 16 entries, entry i resets to byte {i,i} replicated, RDATA two cycles after nEN.
    logic [127:0] mem [16];
    logic [127:0] rd_pipe [2];
    logic         mem_ready = 1'b0;

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d, input logic [3:0] m);
        logic [127:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (!m[k]) r[32*k +: 32] = d[32*k +: 32];
        return r;
    endfunction

    always @(posedge CLK) begin
        logic [127:0] v;
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= {16{i[3:0], i[3:0]}};
            mem_ready <= 1'b1;
        end else begin
            v = '0;
            if (!bus.nEN[0]) v = mem[bus.SRC0A_ADDR[3:0]];
            if (!bus.nEN[1]) v = mem[bus.SRC0B_ADDR[3:0]];
            if (!bus.nEN[2]) v = mem[bus.SRC1A_ADDR[3:0]];
            if (!bus.nEN[3]) v = mem[bus.SRC1B_ADDR[3:0]];
            rd_pipe[0] <= v;
            if (!bus.nEN[4]) mem[bus.WB0_ADDR[3:0]] <= merge(mem[bus.WB0_ADDR[3:0]], bus.WB0_DATA, bus.WB0_WMASK);
            if (!bus.nEN[5]) mem[bus.WB1_ADDR[3:0]] <= merge(mem[bus.WB1_ADDR[3:0]], bus.WB1_DATA, bus.WB1_WMASK);
        end
        rd_pipe[1] <= rd_pipe[0];
    end
    assign bus.RDATA = rd_pipe[1];

    logic [5:0] nen_log [$];
    int         nen_cyc [$];

    always @(negedge CLK) begin
        if (bus.nEN !== NEN_IDLE) begin
            nen_log.push_back(bus.nEN);
            nen_cyc.push_back(cyc);
        end
        if ($countones(~bus.nEN) > 1) onehot_err++;
    end

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] se, input logic [1:0] we,
                         input logic [7:0] a0a, input logic [7:0] a0b, input logic [7:0] a1a,
                         input logic [7:0] a1b, input logic [7:0] w0a, input logic [7:0] w1a,
                         input logic [3:0] m0, input logic [3:0] m1,
                         input logic [127:0] d0, input logic [127:0] d1);
        bus.REQ_SRC_EN     = se;
        bus.REQ_WB_EN      = we;
        bus.REQ_SRC0A_ADDR = a0a;
        bus.REQ_SRC0B_ADDR = a0b;
        bus.REQ_SRC1A_ADDR = a1a;
        bus.REQ_SRC1B_ADDR = a1b;
        bus.REQ_WB0_ADDR   = w0a;
        bus.REQ_WB1_ADDR   = w1a;
        bus.REQ_WB0_WMASK  = m0;
        bus.REQ_WB1_WMASK  = m1;
        bus.REQ_WB0_DATA   = d0;
        bus.REQ_WB1_DATA   = d1;
    endtask

    task automatic issue(input string tag);
        bit ok;
        ok = 1'b0;
        nen_log.delete();
        nen_cyc.delete();
        bus.REQ_VALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.REQ_READY === 1'b1) begin
                t_hs = cyc + 1;
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
        check({tag, "_handshake"}, 128'(ok), 128'(1));
    endtask

    task automatic wait_valid(input string tag, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.OPR_VALID === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge CLK);
        end
        check({tag, "_valid_seen"}, 128'(t >= 0), 128'(1));
    endtask

    task automatic accept(input string tag);
        bus.OPR_READY = 1'b1;
        @(negedge CLK);
        bus.OPR_READY = 1'b0;
        check({tag, "_valid_drop"}, 128'(bus.OPR_VALID), 128'(0));
        check({tag, "_ready_back"}, 128'(bus.REQ_READY), 128'(1));
    endtask

    task automatic check_nen(input string tag, input int n, input logic [5:0] e0,
                             input logic [5:0] e1, input logic [5:0] e2, input logic [5:0] e3);
        logic [5:0] exp_q [4];
        exp_q = '{e0, e1, e2, e3};
        check({tag, "_nen_count"}, 128'(nen_log.size()), 128'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_nen%0d", tag, i), 128'((i < nen_log.size()) ? nen_log[i] : 6'h00), 128'(exp_q[i]));
            check($sformatf("%s_cyc%0d", tag, i), 128'((i < nen_cyc.size()) ? nen_cyc[i] : -1), 128'(t_hs + 1 + i));
        end
    endtask

    initial begin
        int t;
        int stable_err;
        bus.REQ_VALID = 1'b0;
        bus.OPR_READY = 1'b0;
        drive(4'h0, 2'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'h0, 4'h0, '0, '0);

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_nen", 128'(bus.nEN), 128'(6'h3F));
        check("rst_req_ready", 128'(bus.REQ_READY), 128'(1));
        check("rst_opr_valid", 128'(bus.OPR_VALID), 128'(0));
        check("rst_wb0_wmask", 128'(bus.WB0_WMASK), 128'(4'hF));
        check("rst_wb1_wmask", 128'(bus.WB1_WMASK), 128'(4'hF));
        check("rst_wb0_data", bus.WB0_DATA, 128'(0));
        check("rst_src0a_addr", 128'(bus.SRC0A_ADDR), 128'(0));
        check("rst_opr0a", bus.OPR0A, 128'(0));
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        // All four reads
        drive(4'hF, 2'h0, 8'd3, 8'd5, 8'd7, 8'd9, 8'd0, 8'd0, 4'h0, 4'h0, '0, '0);
        issue("t1");
        wait_valid("t1", t);
        check("t1_valid_cycle", 128'(t), 128'(t_hs + 7));
        check_nen("t1", 4, 6'h3E, 6'h3D, 6'h3B, 6'h37);
        check("t1_opr0a", bus.OPR0A, rep(8'h33));
        check("t1_opr0b", bus.OPR0B, rep(8'h55));
        check("t1_opr1a", bus.OPR1A, rep(8'h77));
        check("t1_opr1b", bus.OPR1B, rep(8'h99));
        check("t1_hold_req_ready", 128'(bus.REQ_READY), 128'(0));
        accept("t1");

        // Sparse mix: SRC0A, SRC1A, WB1 (dwords 0,1 masked)
        drive(4'b0101, 2'b10, 8'd2, 8'd11, 8'd6, 8'd12, 8'd13, 8'd10, 4'h0, 4'b0011, rep(8'h5A), rep(8'h3C));
        issue("t2");
        wait_valid("t2", t);
        check_nen("t2", 3, 6'h3E, 6'h3B, 6'h1F, 6'h3F);
        check("t2_opr0a", bus.OPR0A, rep(8'h22));
        check("t2_opr0b", bus.OPR0B, 128'(0));
        check("t2_opr1a", bus.OPR1A, rep(8'h66));
        check("t2_opr1b", bus.OPR1B, 128'(0));
        check("t2_wb1_addr", 128'(bus.WB1_ADDR), 128'(10));
        check("t2_wb1_wmask", 128'(bus.WB1_WMASK), 128'(4'b0011));
        check("t2_wb1_data", bus.WB1_DATA, rep(8'h3C));
        accept("t2");

        // Read and write of the same index: read sees the old value
        drive(4'b0001, 2'b01, 8'd4, 8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 4'h0, 4'hF, rep(8'hA5), '0);
        issue("t3");
        wait_valid("t3", t);
        check_nen("t3", 2, 6'h3E, 6'h2F, 6'h3F, 6'h3F);
        check("t3_opr0a_old", bus.OPR0A, rep(8'h44));
        accept("t3");

        drive(4'b0011, 2'b00, 8'd4, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 4'h0, 4'h0, '0, '0);
        issue("t3b");
        wait_valid("t3b", t);
        check("t3b_opr0a_new", bus.OPR0A, rep(8'hA5));
        check("t3b_opr0b_masked", bus.OPR0B, {rep(8'h3C)[127:64], rep(8'hAA)[63:0]});
        accept("t3b");

        // Empty request
        drive(4'h0, 2'h0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 4'h0, 4'h0, '0, '0);
        issue("t4");
        wait_valid("t4", t);
        check("t4_valid_cycle", 128'(t), 128'(t_hs + 2));
        check("t4_no_nen", 128'(nen_log.size()), 128'(0));
        check("t4_opr0a_zero", bus.OPR0A, 128'(0));
        check("t4_opr0b_zero", bus.OPR0B, 128'(0));
        accept("t4");

        // Consumer stalls for 10 cycles in HOLD
        drive(4'b0001, 2'b00, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 4'h0, 4'h0, '0, '0);
        issue("t5");
        wait_valid("t5", t);
        stable_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.OPR_VALID !== 1'b1 || bus.OPR0A !== rep(8'h11) || bus.REQ_READY !== 1'b0) stable_err++;
        end
        check("t5_hold_stable", 128'(stable_err), 128'(0));
        accept("t5");

        // Reset in the middle of ISSUE, after the second slot
        drive(4'hF, 2'h0, 8'd3, 8'd5, 8'd7, 8'd9, 8'd0, 8'd0, 4'h0, 4'h0, '0, '0);
        issue("t6");
        repeat (2) @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("t6_rst_nen", 128'(bus.nEN), 128'(6'h3F));
        check("t6_rst_opr_valid", 128'(bus.OPR_VALID), 128'(0));
        check("t6_rst_opr0a", bus.OPR0A, 128'(0));
        check("t6_rst_req_ready", 128'(bus.REQ_READY), 128'(1));
        nen_log.delete();
        nen_cyc.delete();
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (5) @(negedge CLK);
        check("t6_no_pulse", 128'(nen_log.size()), 128'(0));
        check("t6_no_valid", 128'(bus.OPR_VALID), 128'(0));

        drive(4'b0011, 2'b00, 8'd8, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 4'h0, 4'h0, '0, '0);
        issue("t6b");
        wait_valid("t6b", t);
        check_nen("t6b", 2, 6'h3E, 6'h3D, 6'h3F, 6'h3F);
        check("t6b_opr0a", bus.OPR0A, rep(8'h88));
        check("t6b_opr0b", bus.OPR0B, rep(8'h99));
        check("t6b_opr1a", bus.OPR1A, 128'(0));
        accept("t6b");

        check("nen_onehot", 128'(onehot_err), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
